// File: rtl/datapath_step_ctrl_pkg.sv
// Shared definitions for the datapath run/step/halt sequencer.
package dp_ctrl_pkg;

    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        RSTSEQ = 2'd0,
        HALTED = 2'd1,
        RUN    = 2'd2,
        STEP   = 2'd3
    } state_t;

endpackage

// File: rtl/datapath_step_ctrl_btn_debounce.sv
// Raw button conditioning: 2-FF synchronizer, debounce filter and
// registered rising-edge event on the accepted level.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);

    localparam int unsigned     CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_level;
    logic          r_level_d;
    logic          r_evt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0   <= 1'b0;
            r_sync1   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_evt     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync0   <= btn;
            r_sync1   <= r_sync0;
            r_level_d <= r_level;
            r_evt     <= r_level & ~r_level_d;
            // Level is accepted only after DB_CYCLES consecutive disagreeing samples.
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign evt = r_evt;

endmodule

// File: rtl/datapath_step_ctrl.sv
// Run/step/halt sequencer issuing a one-cycle clock enable to the SAD datapath,
// with PC breakpoint, reset sequencing and a pulse counter.
module datapath_step_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_run,
    input  logic            btn_step,
    input  logic            btn_halt,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] halt_pc,
    input  logic            bp_en,
    output logic            dp_en,
    output logic            dp_rst,
    output logic [1:0]      state,
    output logic [31:0]     cycle_cnt
);

    localparam int unsigned   TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam int unsigned   RW        = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES);

    logic          w_ev_run;
    logic          w_ev_step;
    logic          w_ev_halt;
    logic          w_due;
    logic          w_bp_hit;
    logic          w_dp_en_nxt;
    state_t        w_state_nxt;

    state_t        r_state;
    logic          r_dp_en;
    logic          r_dp_rst;
    logic          r_first;
    logic [TW-1:0] r_tick;
    logic [RW-1:0] r_rstcnt;
    logic [31:0]   r_cycle_cnt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk (clk), .rst (rst), .btn (btn_run),  .evt (w_ev_run)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk (clk), .rst (rst), .btn (btn_step), .evt (w_ev_step)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_halt (
        .clk (clk), .rst (rst), .btn (btn_halt), .evt (w_ev_halt)
    );

    // Outputs are registered, so the enable is decided here and lands with the state.
    always_comb begin
        w_state_nxt = r_state;
        w_dp_en_nxt = 1'b0;
        w_due       = (r_tick == TICK_LAST);
        w_bp_hit    = bp_en && (pc == halt_pc);
        unique case (r_state)
            RSTSEQ: begin
                if (r_rstcnt == RST_LAST) w_state_nxt = HALTED;
            end
            HALTED: begin
                if (w_ev_halt) begin
                    w_state_nxt = HALTED;
                end else if (w_ev_step) begin
                    w_state_nxt = STEP;
                    w_dp_en_nxt = 1'b1;
                end else if (w_ev_run) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_ev_halt || w_ev_step) begin
                    w_state_nxt = HALTED;
                end else if (w_due) begin
                    if (w_bp_hit && !r_first) w_state_nxt = HALTED;
                    else                      w_dp_en_nxt = 1'b1;
                end
            end
            STEP: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt = RSTSEQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RSTSEQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_en     <= 1'b0;
            r_dp_rst    <= 1'b1;
            r_first     <= 1'b0;
            r_tick      <= '0;
            r_rstcnt    <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_dp_en     <= w_dp_en_nxt;
            r_dp_rst    <= (w_state_nxt == RSTSEQ);
            r_cycle_cnt <= r_cycle_cnt + {31'd0, w_dp_en_nxt};
            r_tick      <= (r_state == RUN && w_state_nxt == RUN && !w_due)
                           ? r_tick + TW'(1) : '0;
            r_rstcnt    <= (r_state == RSTSEQ && w_state_nxt == RSTSEQ)
                           ? r_rstcnt + RW'(1) : '0;
            // Armed on RUN entry so the first due pulse can leave a breakpoint.
            r_first     <= (w_state_nxt == RUN) &&
                           ((r_state != RUN) || (r_first && !w_due));
        end
    end

    assign dp_en     = r_dp_en;
    assign dp_rst    = r_dp_rst;
    assign state     = r_state;
    assign cycle_cnt = r_cycle_cnt;

endmodule
